// File: rtl/uart_pkg.sv
// Shared 57600-baud 8N1 timing constants and receiver state encoding for the serial link.
// The transmitter on the same link takes its bit timing from here too.
package uart_pkg;

    localparam int BPS_END  = 868;
    localparam int BPS_HALF = 434;
    localparam int BIT_NUM  = 8;

    localparam int BPS_W = 13;
    localparam int BIT_W = 4;

    localparam logic [BPS_W-1:0] BPS_END_M1  = BPS_W'(BPS_END - 1);
    localparam logic [BPS_W-1:0] BPS_HALF_M1 = BPS_W'(BPS_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(BIT_NUM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the async rx pin into clk_50: 2-FF synchronizer plus a delay flop for fall detection.
// Latency: rx_s_o lags the pin by 2 cycles, fall_o is combinational off rx_s_o/delay flop; no backpressure.
module uart_rx_sync (
    input  logic clk_50,
    input  logic rst_n,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic rx_meta_q;
    logic rx_s_q;
    logic rx_d_q;

    // Reset to idle-high so a line held low across reset release is not seen as a start edge.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
        end
    end

    assign rx_s_o = rx_s_q;
    assign fall_o = rx_d_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, glitch-start rejection, framing-error flag.
// Latency: byte/err pulse 1 cycle after the stop-bit mid-sample; no backpressure (pulses are fire-and-forget).
module uart_rx
    import uart_pkg::*;
(
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic       frm_err,
    output logic       busy
);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .rx_i   (rx),
        .rx_s_o (rx_s),
        .fall_o (rx_fall)
    );

    rx_state_e          state_q, state_d;
    logic [BPS_W-1:0]   bps_cnt_q, bps_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BIT_NUM-1:0] shift_q, shift_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_vld_q, rx_vld_d;
    logic               frm_err_q, frm_err_d;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bps_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rx_vld_q  <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bps_cnt_q <= bps_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rx_vld_q  <= rx_vld_d;
            frm_err_q <= frm_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bps_cnt_d = bps_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        rx_vld_d  = 1'b0;
        frm_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    state_d   = START;
                    bps_cnt_d = '0;
                end
            end
            START: begin
                // Line must still be low at mid-start, otherwise treat the edge as a glitch.
                if (bps_cnt_q == BPS_HALF_M1) begin
                    bps_cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end else begin
                    bps_cnt_d = bps_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bps_cnt_q == BPS_END_M1) begin
                    bps_cnt_d = '0;
                    // LSB arrives first, so shift right and it lands at bit 0 after the last data bit.
                    shift_d   = {rx_s, shift_q[BIT_NUM-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    bps_cnt_d = bps_cnt_q + 1'b1;
                end
            end
            STOP: begin
                // Leaving at mid-stop gives half a bit of slack for a back-to-back start edge.
                if (bps_cnt_q == BPS_END_M1) begin
                    bps_cnt_d = '0;
                    state_d   = IDLE;
                    if (rx_s) begin
                        rx_data_d = shift_q;
                        rx_vld_d  = 1'b1;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end else begin
                    bps_cnt_d = bps_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data = rx_data_q;
    assign rx_vld  = rx_vld_q;
    assign frm_err = frm_err_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: nominal, back-to-back, glitch, framing error, mid-frame reset, +-2% baud.
module tb_uart_rx;

    logic       clk_50;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic       frm_err;
    logic       busy;

    uart_rx dut (
        .clk_50  (clk_50),
        .rst_n   (rst_n),
        .rx      (rx),
        .rx_data (rx_data),
        .rx_vld  (rx_vld),
        .frm_err (frm_err),
        .busy    (busy)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    int cyc = 0;
    always @(posedge clk_50) cyc++;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge away from DUT updates.
    int         vld_cnt   = 0;
    int         err_cnt   = 0;
    int         vld_cyc   = -1;
    int         err_cyc   = -1;
    logic [7:0] vld_dat   = '0;
    logic       vld_busy  = 1'b0;
    logic       both_seen = 1'b0;

    always @(negedge clk_50) begin
        if (rx_vld) begin
            vld_cnt++;
            vld_cyc  = cyc;
            vld_dat  = rx_data;
            vld_busy = busy;
        end
        if (frm_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (rx_vld && frm_err) both_seen = 1'b1;
    end

    // Called on a falling edge; start bit driven in that cycle (n0). Start edge D = n0+2,
    // so a result pulse is expected in cycle n0 + 2 + 434 + 9*868 + 1 = n0 + 8249.
    task automatic send_frame(input logic [7:0] b, input int bclk, input logic stop_bit,
                              output int n0);
        logic [9:0] f;
        f  = {stop_bit, b, 1'b0};
        n0 = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (bclk) @(negedge clk_50);
        end
    endtask

    int         n0a, n0b, n0;
    int         v0, e0, first_cyc;
    logic [7:0] first_dat;

    logic [7:0] lb_byte [4];
    int         lb_bclk [4];

    initial begin
        lb_byte[0] = 8'h00; lb_bclk[0] = 851;
        lb_byte[1] = 8'hFF; lb_bclk[1] = 885;
        lb_byte[2] = 8'h6B; lb_bclk[2] = 851;
        lb_byte[3] = 8'h6B; lb_bclk[3] = 885;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk_50);
        chk("reset rx_data", 32'(rx_data), 32'h00);
        chk("reset rx_vld",  32'(rx_vld),  32'h0);
        chk("reset frm_err", 32'(frm_err), 32'h0);
        chk("reset busy",    32'(busy),    32'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk_50);

        // 1: nominal 0x55
        send_frame(8'h55, 868, 1'b1, n0a);
        chk("t1 vld count", 32'(vld_cnt), 32'd1);
        chk("t1 vld cycle", 32'(vld_cyc - n0a), 32'd8249);
        chk("t1 data",      32'(vld_dat), 32'h55);
        chk("t1 busy at pulse", 32'(vld_busy), 32'h0);
        chk("t1 no err",    32'(err_cnt), 32'd0);
        repeat (100) @(negedge clk_50);

        // 2: back-to-back 0xA5, 0x3C with zero idle
        v0 = vld_cnt;
        send_frame(8'hA5, 868, 1'b1, n0a);
        first_cyc = vld_cyc;
        first_dat = vld_dat;
        send_frame(8'h3C, 868, 1'b1, n0b);
        chk("t2 frame spacing", 32'(n0b - n0a), 32'd8680);
        chk("t2 first data",  32'(first_dat), 32'hA5);
        chk("t2 first cycle", 32'(first_cyc - n0a), 32'd8249);
        chk("t2 second data", 32'(vld_dat), 32'h3C);
        chk("t2 pulse spacing", 32'(vld_cyc - first_cyc), 32'd8680);
        chk("t2 vld count", 32'(vld_cnt - v0), 32'd2);
        repeat (100) @(negedge clk_50);

        // 3: 200-cycle glitch start; D = n0+2, back to IDLE in cycle D+435 = n0+437
        v0 = vld_cnt;
        e0 = err_cnt;
        n0 = cyc;
        rx = 1'b0;
        repeat (100) @(negedge clk_50);
        chk("t3 busy during start", 32'(busy), 32'h1);
        repeat (100) @(negedge clk_50);
        rx = 1'b1;
        repeat (236) @(negedge clk_50);
        chk("t3 busy at mid-start", 32'(busy), 32'h1);
        @(negedge clk_50);
        chk("t3 busy after reject", 32'(busy), 32'h0);
        chk("t3 reject cycle", 32'(cyc - n0), 32'd437);
        repeat (9000) @(negedge clk_50);
        chk("t3 no vld",  32'(vld_cnt - v0), 32'd0);
        chk("t3 no err",  32'(err_cnt - e0), 32'd0);
        chk("t3 data kept", 32'(rx_data), 32'h3C);

        // 4: 0x81 with low stop bit, then line held low (break)
        v0 = vld_cnt;
        e0 = err_cnt;
        send_frame(8'h81, 868, 1'b0, n0a);
        chk("t4 err count", 32'(err_cnt - e0), 32'd1);
        chk("t4 err cycle", 32'(err_cyc - n0a), 32'd8249);
        chk("t4 no vld",    32'(vld_cnt - v0), 32'd0);
        chk("t4 data kept", 32'(rx_data), 32'h3C);
        repeat (2000) @(negedge clk_50);
        chk("t4 break no restart", 32'(busy), 32'h0);
        rx = 1'b1;
        repeat (1000) @(negedge clk_50);
        chk("t4 no extra err", 32'(err_cnt - e0), 32'd1);

        // 5: reset during data bit 4 of 0xF0, then 0x12
        v0 = vld_cnt;
        e0 = err_cnt;
        fork
            send_frame(8'hF0, 868, 1'b1, n0a);
            begin
                repeat (5 * 868 + 400) @(negedge clk_50);
                rst_n = 1'b0;
                #1;
                chk("t5 reset busy",    32'(busy),    32'h0);
                chk("t5 reset rx_data", 32'(rx_data), 32'h00);
                repeat (10) @(negedge clk_50);
                rst_n = 1'b1;
            end
        join
        repeat (2000) @(negedge clk_50);
        chk("t5 aborted no vld", 32'(vld_cnt - v0), 32'd0);
        chk("t5 aborted no err", 32'(err_cnt - e0), 32'd0);
        send_frame(8'h12, 868, 1'b1, n0a);
        chk("t5 vld count", 32'(vld_cnt - v0), 32'd1);
        chk("t5 data",      32'(rx_data), 32'h12);
        chk("t5 vld cycle", 32'(vld_cyc - n0a), 32'd8249);
        repeat (200) @(negedge clk_50);

        // 6: +-2% baud
        e0 = err_cnt;
        for (int k = 0; k < 4; k++) begin
            v0 = vld_cnt;
            send_frame(lb_byte[k], lb_bclk[k], 1'b1, n0a);
            repeat (300) @(negedge clk_50);
            chk($sformatf("t6 vld count %0d", k), 32'(vld_cnt - v0), 32'd1);
            chk($sformatf("t6 data %0d", k), 32'(vld_dat), 32'(lb_byte[k]));
            chk($sformatf("t6 vld cycle %0d", k), 32'(vld_cyc - n0a), 32'd8249);
        end
        chk("t6 no err", 32'(err_cnt - e0), 32'd0);

        chk("vld and err never together", 32'(both_seen), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
